// File: rtl/router_pkg.sv
// Shared types for the routing crossbar: packet format, index widths and the
// default node-to-output-port route table.
package router_pkg;

  localparam int NODE_W            = 4;
  localparam int PORT_W            = 3;
  localparam int DATA_W            = 16;
  localparam int STAT_W            = 16;
  localparam int DEFAULT_NUM_NODES = 6;

  typedef logic [NODE_W-1:0] node_idx_t;
  typedef logic [PORT_W-1:0] port_idx_t;

  typedef struct packed {
    node_idx_t         dest;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef logic [DEFAULT_NUM_NODES-1:0][PORT_W-1:0] route_table_t;

  // Element 0 is the rightmost entry: node0->0, node1->2, node2->3, rest->1.
  localparam route_table_t DEFAULT_ROUTE_TABLE = {
    port_idx_t'(1), port_idx_t'(1), port_idx_t'(1),
    port_idx_t'(3), port_idx_t'(2), port_idx_t'(0)
  };

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after its own pointer and
// moves the pointer just past the winner; grants nothing and holds when disabled.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] win;
  logic [N-1:0]     rotated;
  logic             found;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    grant   = '0;
    win     = '0;
    found   = 1'b0;
    rotated = enable ? N'({req, req} >> ptr) : '0;
    // Scan downwards so the lowest rotated position (closest to ptr) wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr) + j) % N);
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = found && (win == PTR_W'(i));
    end
    ptr_next = ptr;
    if (found) begin
      ptr_next = (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/routing_xbar_rr.sv
// NUM_PORTS x NUM_PORTS packet crossbar with per-output round-robin arbitration
// and one-entry output registers. Define ROUTING_STATS_EN for forward counters.
module routing_xbar_rr
  import router_pkg::*;
#(
  parameter int                               NUM_PORTS    = 4,
  parameter int                               NUM_NODES    = 6,
  parameter logic [NUM_NODES-1:0][PORT_W-1:0] ROUTE_TABLE  = DEFAULT_ROUTE_TABLE,
  parameter int                               DEFAULT_PORT = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0]              pkt_in_avail,
  input  pkt_t [NUM_PORTS-1:0]              pkt_in,
  output logic [NUM_PORTS-1:0]              read_from_ib,
  input  logic [NUM_PORTS-1:0]              ob_ready_to_recv,
  output pkt_t [NUM_PORTS-1:0]              pkt_out,
  output logic [NUM_PORTS-1:0]              pkt_out_avail,
  output logic [NUM_PORTS-1:0][STAT_W-1:0]  stat_fwd_count
);

  port_idx_t [NUM_PORTS-1:0]                route;
  logic      [NUM_PORTS-1:0][NUM_PORTS-1:0] req;    // [output][input]
  logic      [NUM_PORTS-1:0][NUM_PORTS-1:0] grant;  // [output][input]
  logic      [NUM_PORTS-1:0]                can_load;
  logic      [NUM_PORTS-1:0]                xfer;
  logic      [NUM_PORTS-1:0]                load;
  pkt_t      [NUM_PORTS-1:0]                load_pkt;

  // Destinations outside the table fall through to DEFAULT_PORT.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = port_idx_t'(DEFAULT_PORT);
      for (int n = 0; n < NUM_NODES; n++) begin
        if (int'(pkt_in[i].dest) == n) route[i] = ROUTE_TABLE[n];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      xfer[o]     = pkt_out_avail[o] && ob_ready_to_recv[o];
      can_load[o] = reset_n && (!pkt_out_avail[o] || ob_ready_to_recv[o]);
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = pkt_in_avail[i] && (int'(route[i]) == o);
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    rr_arbiter #(
      .N (NUM_PORTS)
    ) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req[o]),
      .enable  (can_load[o]),
      .grant   (grant[o])
    );
  end

  // Each input routes to one output, so the OR of per-output grants is one-hot per input.
  always_comb begin
    read_from_ib = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      load[o]     = |grant[o];
      load_pkt[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[o][i]) load_pkt[o] = pkt_in[i];
      end
      read_from_ib = read_from_ib | grant[o];
    end
  end

  // NOTE: the packet register is reset along with its valid bit so pkt_out reads 0 after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_out       <= '0;
      pkt_out_avail <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (load[o]) begin
          pkt_out[o]       <= load_pkt[o];
          pkt_out_avail[o] <= 1'b1;
        end else if (xfer[o]) begin
          pkt_out_avail[o] <= 1'b0;
        end
      end
    end
  end

`ifdef ROUTING_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fwd_count <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (xfer[o] && (stat_fwd_count[o] != {STAT_W{1'b1}})) begin
          stat_fwd_count[o] <= stat_fwd_count[o] + 1'b1;
        end
      end
    end
  end
`else
  assign stat_fwd_count = '0;
`endif

endmodule

// File: tb/tb_routing_xbar_rr.sv
// Bench for routing_xbar_rr: directed scenarios plus randomized traffic, all
// checked against a cycle-level reference model of input queues and output slots.
module tb_routing_xbar_rr;
  import router_pkg::*;

  localparam int NP = 4;
  localparam int NN = 6;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [NP-1:0]          pkt_in_avail;
  pkt_t [NP-1:0]          pkt_in;
  logic [NP-1:0]          read_from_ib;
  logic [NP-1:0]          ob_ready_to_recv;
  pkt_t [NP-1:0]          pkt_out;
  logic [NP-1:0]          pkt_out_avail;
  logic [NP-1:0][15:0]    stat_fwd_count;

  routing_xbar_rr #(
    .NUM_PORTS (NP),
    .NUM_NODES (NN)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pkt_in_avail     (pkt_in_avail),
    .pkt_in           (pkt_in),
    .read_from_ib     (read_from_ib),
    .ob_ready_to_recv (ob_ready_to_recv),
    .pkt_out          (pkt_out),
    .pkt_out_avail    (pkt_out_avail),
    .stat_fwd_count   (stat_fwd_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int seq   = 0;

  // Reference state: input buffers, output slots, arbitration pointers, counts.
  pkt_t q[NP][$];
  bit   m_full[NP];
  pkt_t m_pkt[NP];
  int   m_ptr[NP];
  int   m_fwd[NP];
  int   pushed_to[NP];
  int   seen_at[NP];
  int   tbl[NN] = '{0, 2, 3, 1, 1, 1};

  logic [NP-1:0] obs_rd;
  logic [NP-1:0] obs_av;
  pkt_t [NP-1:0] obs_pkt;

  function automatic int route_ref(int dest);
    if (dest >= NN) return 1;
    return tbl[dest];
  endfunction

  function automatic logic [15:0] exp_stat(int n);
`ifdef ROUTING_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'hFFFF : 16'h0;
`endif
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      pkt_in_avail[i] = (q[i].size() > 0);
      pkt_in[i]       = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  task automatic push(int i, int dest);
    pkt_t p;
    p.dest = node_idx_t'(dest);
    p.data = {i[3:0], seq[11:0]};
    seq++;
    q[i].push_back(p);
    pushed_to[route_ref(dest)]++;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NP; k++) begin
      q[k].delete();
      m_full[k]    = 1'b0;
      m_pkt[k]     = '0;
      m_ptr[k]     = 0;
      m_fwd[k]     = 0;
      pushed_to[k] = 0;
      seen_at[k]   = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    ob_ready_to_recv = '1;
    drive_inputs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock cycle: predict grants, compare at the falling edge, then advance the model.
  task automatic run_cycle();
    logic [NP-1:0] exp_rd;
    int            g[NP];
    bit            xfer;
    drive_inputs();
    exp_rd = '0;
    for (int o = 0; o < NP; o++) begin
      g[o] = -1;
      if (!m_full[o] || ob_ready_to_recv[o]) begin
        for (int k = 0; k < NP; k++) begin
          int i;
          i = (m_ptr[o] + k) % NP;
          if (g[o] < 0 && q[i].size() > 0 && route_ref(int'(q[i][0].dest)) == o) g[o] = i;
        end
      end
      if (g[o] >= 0) exp_rd[g[o]] = 1'b1;
    end
    @(negedge clock);
    cyc++;
    obs_rd  = read_from_ib;
    obs_av  = pkt_out_avail;
    obs_pkt = pkt_out;
    n_cmp++;
    if (read_from_ib !== exp_rd) begin
      n_bad++;
      $display("FAIL read_from_ib cyc=%0d got=%b exp=%b", cyc, read_from_ib, exp_rd);
    end
    for (int o = 0; o < NP; o++) begin
      n_cmp++;
      if (pkt_out_avail[o] !== m_full[o]) begin
        n_bad++;
        $display("FAIL pkt_out_avail[%0d] cyc=%0d got=%b exp=%b", o, cyc, pkt_out_avail[o], m_full[o]);
      end
      if (m_full[o]) begin
        n_cmp++;
        if (pkt_out[o] !== m_pkt[o]) begin
          n_bad++;
          $display("FAIL pkt_out[%0d] cyc=%0d got=%h exp=%h", o, cyc, pkt_out[o], m_pkt[o]);
        end
      end
      n_cmp++;
      if (stat_fwd_count[o] !== exp_stat(m_fwd[o])) begin
        n_bad++;
        $display("FAIL stat_fwd_count[%0d] cyc=%0d got=%h exp=%h", o, cyc, stat_fwd_count[o],
                 exp_stat(m_fwd[o]));
      end
      if (pkt_out_avail[o] === 1'b1 && ob_ready_to_recv[o]) seen_at[o]++;
    end
    @(posedge clock);
    for (int o = 0; o < NP; o++) begin
      xfer = m_full[o] && ob_ready_to_recv[o];
      if (xfer) m_fwd[o]++;
      if (g[o] >= 0) begin
        m_pkt[o]  = q[g[o]][0];
        m_full[o] = 1'b1;
        m_ptr[o]  = (g[o] + 1) % NP;
      end else if (xfer) begin
        m_full[o] = 1'b0;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (exp_rd[i]) void'(q[i].pop_front());
    end
    #1;
    drive_inputs();
  endtask

  // Flush everything with all outputs ready, then account for every packet.
  task automatic drain_and_account(string tag);
    int  n;
    bit  pending;
    ob_ready_to_recv = '1;
    n = 0;
    pending = 1'b1;
    while (pending && n < 200) begin
      run_cycle();
      n++;
      pending = 1'b0;
      for (int k = 0; k < NP; k++) if (q[k].size() > 0 || m_full[k]) pending = 1'b1;
    end
    n_cmp++;
    if (pending) begin
      n_bad++;
      $display("FAIL %s drain timeout after %0d cycles", tag, n);
    end
    for (int o = 0; o < NP; o++) begin
      n_cmp++;
      if (seen_at[o] !== pushed_to[o]) begin
        n_bad++;
        $display("FAIL %s delivered[%0d] got=%0d exp=%0d", tag, o, seen_at[o], pushed_to[o]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_model();
    ob_ready_to_recv = '1;
    for (int i = 0; i < NP; i++) push(i, i);
    drive_inputs();
    #2;
    n_cmp++;
    if (read_from_ib !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_read got=%b exp=0000", read_from_ib);
    end
    n_cmp++;
    if (pkt_out_avail !== 4'b0000 || pkt_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs avail=%b pkt=%h exp=0", pkt_out_avail, pkt_out);
    end
    n_cmp++;
    if (stat_fwd_count !== '0) begin
      n_bad++;
      $display("FAIL reset_stats got=%h exp=0", stat_fwd_count);
    end
    @(posedge clock);
    @(posedge clock);
    #1;
    n_cmp++;
    if (read_from_ib !== 4'b0000 || pkt_out_avail !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_held rd=%b avail=%b exp=0000/0000", read_from_ib, pkt_out_avail);
    end
    do_reset();
  endtask

  task automatic test_single();
    pkt_t p;
    do_reset();
    push(0, 1);
    p = q[0][0];
    run_cycle();
    n_cmp++;
    if (obs_rd !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_read got=%b exp=0001", obs_rd);
    end
    run_cycle();
    n_cmp++;
    if (obs_av !== 4'b0100 || obs_pkt[2] !== p) begin
      n_bad++;
      $display("FAIL single_out avail=%b pkt2=%h exp=0100/%h", obs_av, obs_pkt[2], p);
    end
    drain_and_account("single");
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < NP; i++) for (int k = 0; k < 3; k++) push(i, 2);
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      n_cmp++;
      if (obs_rd !== exp_seq[c]) begin
        n_bad++;
        $display("FAIL rr_order step=%0d got=%b exp=%b", c, obs_rd, exp_seq[c]);
      end
    end
    drain_and_account("rr");
  endtask

  task automatic test_backpressure();
    pkt_t held;
    do_reset();
    ob_ready_to_recv = 4'b0111;
    push(0, 2); push(0, 2); push(1, 2); push(1, 2);
    held = q[0][0];
    run_cycle();
    n_cmp++;
    if (obs_rd !== 4'b0001) begin
      n_bad++;
      $display("FAIL bp_first got=%b exp=0001", obs_rd);
    end
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      n_cmp++;
      if (obs_rd !== 4'b0000 || obs_av[3] !== 1'b1 || obs_pkt[3] !== held) begin
        n_bad++;
        $display("FAIL bp_hold step=%0d rd=%b av3=%b pkt3=%h exp=0000/1/%h", c, obs_rd, obs_av[3],
                 obs_pkt[3], held);
      end
    end
    ob_ready_to_recv = '1;
    run_cycle();
    n_cmp++;
    if (obs_rd !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_resume got=%b exp=0010", obs_rd);
    end
    drain_and_account("bp");
  endtask

  task automatic test_parallel();
    do_reset();
    for (int i = 0; i < NP; i++) push(i, i);
    run_cycle();
    n_cmp++;
    if (obs_rd !== 4'b1111) begin
      n_bad++;
      $display("FAIL parallel_read got=%b exp=1111", obs_rd);
    end
    run_cycle();
    n_cmp++;
    if (obs_av !== 4'b1111) begin
      n_bad++;
      $display("FAIL parallel_avail got=%b exp=1111", obs_av);
    end
    drain_and_account("parallel");
  endtask

  task automatic test_default_and_reset();
    do_reset();
    push(2, 7);
    run_cycle();
    n_cmp++;
    if (obs_rd !== 4'b0100) begin
      n_bad++;
      $display("FAIL default_read got=%b exp=0100", obs_rd);
    end
    run_cycle();
    n_cmp++;
    if (obs_av !== 4'b0010 || obs_pkt[1].dest !== 4'd7) begin
      n_bad++;
      $display("FAIL default_out avail=%b dest=%0d exp=0010/7", obs_av, obs_pkt[1].dest);
    end
    drain_and_account("default");
    for (int i = 0; i < NP; i++) for (int k = 0; k < 4; k++) push(i, 2);
    for (int c = 0; c < 3; c++) run_cycle();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (pkt_out_avail !== 4'b0000 || pkt_out !== '0 || read_from_ib !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_reset avail=%b pkt=%h rd=%b exp=0", pkt_out_avail, pkt_out, read_from_ib);
    end
    do_reset();
    for (int i = 0; i < NP; i++) push(i, 2);
    run_cycle();
    n_cmp++;
    if (obs_rd !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_restart got=%b exp=0001", obs_rd);
    end
    drain_and_account("restart");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (q[i].size() < 4 && $urandom_range(0, 2) != 0) push(i, int'($urandom_range(0, 15)));
      end
      ob_ready_to_recv = 4'($urandom | $urandom);
      run_cycle();
    end
    drain_and_account("random");
  endtask

  task automatic test_stats();
    int n_cycles;
`ifdef ROUTING_STATS_EN
    n_cycles = 70010;
`else
    n_cycles = 300;
`endif
    do_reset();
    for (int c = 0; c < n_cycles; c++) begin
      while (q[0].size() < 2) push(0, 0);
      run_cycle();
    end
    n_cmp++;
`ifdef ROUTING_STATS_EN
    if (stat_fwd_count[0] !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL stats_saturate got=%h exp=ffff", stat_fwd_count[0]);
    end
`else
    if (stat_fwd_count[0] !== 16'h0000) begin
      n_bad++;
      $display("FAIL stats_disabled got=%h exp=0000", stat_fwd_count[0]);
    end
`endif
    drain_and_account("stats");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_parallel();
    test_default_and_reset();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/routing_xbar_rr.md
ROUTING_XBAR_RR -- requirements
Module: routing_xbar_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of input and output ports (2..8).
REQ-002 SHALL have parameter NUM_NODES, default 6, number of addressable destination nodes.
REQ-003 SHALL have parameter ROUTE_TABLE, default router_pkg::DEFAULT_ROUTE_TABLE, per-node output-port index array [NUM_NODES].
REQ-004 SHALL have parameter DEFAULT_PORT, default 1, output for any dest >= NUM_NODES.
REQ-005 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pkt_in_avail, input, NUM_PORTS, packet present at head of input buffer i.
REQ-008 SHALL have port pkt_in, input, NUM_PORTS x pkt_t, head packet per input.
REQ-009 SHALL have port read_from_ib, output, NUM_PORTS, pop input buffer i at this edge.
REQ-010 SHALL have port ob_ready_to_recv, input, NUM_PORTS, downstream output buffer o accepts.
REQ-011 SHALL have port pkt_out, output, NUM_PORTS x pkt_t, registered packet per output.
REQ-012 SHALL have port pkt_out_avail, output, NUM_PORTS, pkt_out[o] valid.
REQ-013 SHALL have port stat_fwd_count, output, NUM_PORTS x 16, forwarded-packet count per output.

Function
REQ-014 SHALL route input i to output ROUTE_TABLE[pkt_in[i].dest], or DEFAULT_PORT if dest >= NUM_NODES.
REQ-015 SHALL raise request(i,o) only when pkt_in_avail[i] and route(i)==o; each input requests at most one output.
REQ-016 SHALL, per output, hold a one-entry output register; transfer occurs when pkt_out_avail[o] && ob_ready_to_recv[o].
REQ-017 SHALL allow output o to load when its register is empty or transferring in the same cycle (full throughput, no bubble).
REQ-018 SHALL, per output, grant the first requesting input at or after rr_ptr[o], searching cyclically modulo NUM_PORTS.
REQ-019 SHALL issue no grant on output o when it cannot load; rr_ptr[o] then holds.
REQ-020 SHALL, on a grant to input g, set rr_ptr[o] <= (g+1) mod NUM_PORTS at the edge.
REQ-021 SHALL assert read_from_ib[i] combinationally in the grant cycle; pkt_in[i] captured into output register at that edge.
REQ-022 SHALL present a granted packet on pkt_out with pkt_out_avail high exactly 1 cycle after read_from_ib.
REQ-023 SHALL hold pkt_out[o] and pkt_out_avail[o] stable while ob_ready_to_recv[o] is low.
REQ-024 SHALL clear pkt_out_avail[o] after a transfer when no new grant occurs that cycle.
REQ-025 SHALL never assert read_from_ib[i] without pkt_in_avail[i]; no packet SHALL be dropped or duplicated.
REQ-026 SHALL treat independent outputs concurrently: up to NUM_PORTS grants per cycle.

Reset
REQ-027 SHALL, on reset_n low, asynchronously clear pkt_out_avail, pkt_out, all rr_ptr to 0, stat_fwd_count to 0.
REQ-028 SHALL hold read_from_ib at 0 while reset_n is low; a packet in an output register at reset is discarded.

Configuration
REQ-029 SHALL, with ROUTING_STATS_EN defined, increment stat_fwd_count[o] by 1 on each transfer, saturating at 16'hFFFF.
REQ-030 SHALL, without ROUTING_STATS_EN, tie stat_fwd_count to 0 and synthesise no counters.

Structure
REQ-031 SHALL take pkt_t, node/port index widths and DEFAULT_ROUTE_TABLE (node0->0, node1->2, node2->3, others->1) from router_pkg.
REQ-032 SHALL implement per-output arbitration in one sub-module rr_arbiter (NUM_PORTS requests, enable, one-hot grant, owned pointer), instantiated NUM_PORTS times.

Verification
REQ-033 SHALL cover: single pkt input 0 dest node1, all ready -> read_from_ib=0001 cycle N, pkt_out[2] avail cycle N+1.
REQ-034 SHALL cover: inputs 0..3 all dest node2 continuously, ready=1 -> output 3 serves 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL cover: ob_ready_to_recv[3]=0 for 5 cycles with pkt held -> pkt_out[3] stable, no further read_from_ib for dest 3, rr_ptr frozen.
REQ-036 SHALL cover: 4 inputs to 4 distinct outputs -> read_from_ib=1111 in one cycle, all 4 outputs valid next cycle.
REQ-037 SHALL cover: dest=7 with NUM_NODES=6 -> routed to output 1; reset_n pulsed mid-burst -> all outputs 0 asynchronously, arbitration restarts at input 0.
REQ-038 SHALL cover: ROUTING_STATS_EN defined, 70000 transfers on output 0 -> stat_fwd_count[0]=16'hFFFF; undefined -> 0.
